// File: rtl/link_output_stage_if.sv
// Buffer-read and outgoing-link signals of the link output stage.
// The slave modport is the stage itself; the master side feeds the buffer head and watches the link.
interface link_output_stage_if #(
  parameter int FLIT_SIZE = 16,
  parameter int CREDITS   = 8
);
  localparam int CW = $clog2(CREDITS + 1);

  logic [FLIT_SIZE-1:0] buf_data_i;
  logic                 buf_empty_i;
  logic                 buf_read_o;
  logic                 hold_i;
  logic                 credit_i;
  logic [FLIT_SIZE-1:0] flit_o;
  logic                 flit_valid_o;
  logic [CW-1:0]        credits_o;
  logic                 pkt_active_o;
  logic                 err_o;

  modport slave (
    input  buf_data_i, buf_empty_i, hold_i, credit_i,
    output buf_read_o, flit_o, flit_valid_o, credits_o, pkt_active_o, err_o
  );

  modport master (
    output buf_data_i, buf_empty_i, hold_i, credit_i,
    input  buf_read_o, flit_o, flit_valid_o, credits_o, pkt_active_o, err_o
  );
endinterface

// File: rtl/link_output_stage.sv
// Pops flits from the input buffer onto the outgoing link under credit flow control,
// tracks packet framing from the flit-type field and raises a sticky error flag.
module link_output_stage #(
  parameter int FLIT_SIZE = 16,
  parameter int CREDITS   = 8
) (
  input  logic               clk,
  input  logic               rst,
  link_output_stage_if.slave link
);

  localparam int            CW       = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  typedef enum logic [1:0] {
    FT_HEAD     = 2'b00,
    FT_BODY     = 2'b01,
    FT_TAIL     = 2'b10,
    FT_HEADTAIL = 2'b11
  } flit_type_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  logic [FLIT_SIZE-1:0] flit_p1;
  logic                 vld_p1;
  logic [CW-1:0]        credits_p1;
  logic                 err_p1;
  state_t               state_p1;

  logic                 pop;
  flit_type_t           ftype;

  function automatic logic [CW-1:0] next_credits(input logic [CW-1:0] cur,
                                                 input logic          dec,
                                                 input logic          inc);
    logic [CW-1:0] res;
    res = cur;
    case ({dec, inc})
      2'b10:   res = cur - 1'b1;
      2'b01:   res = (cur == CRED_MAX) ? cur : cur + 1'b1;
      default: res = cur;
    endcase
    return res;
  endfunction

  function automatic logic credit_overflow(input logic [CW-1:0] cur,
                                           input logic          dec,
                                           input logic          inc);
    return inc & ~dec & (cur == CRED_MAX);
  endfunction

  function automatic logic frame_error(input state_t st, input flit_type_t ft);
    logic bad;
    bad = 1'b0;
    case (st)
      IDLE:    bad = (ft == FT_BODY) || (ft == FT_TAIL);
      ACTIVE:  bad = (ft == FT_HEAD) || (ft == FT_HEADTAIL);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // An out-of-place flit leaves the state untouched.
  function automatic state_t next_state(input state_t st, input flit_type_t ft);
    state_t ns;
    ns = st;
    case (st)
      IDLE:    ns = (ft == FT_HEAD) ? ACTIVE : IDLE;
      ACTIVE:  ns = (ft == FT_TAIL) ? IDLE : ACTIVE;
      default: ns = IDLE;
    endcase
    return ns;
  endfunction

  // Stage p0: buffer head decode and pop decision
  assign ftype = flit_type_t'(link.buf_data_i[FLIT_SIZE-1 -: 2]);
  assign pop   = ~link.buf_empty_i & ~link.hold_i & (credits_p1 != '0);

  assign link.buf_read_o = pop;

  // Stage p1: registered link flit, credit count and framing state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flit_p1    <= '0;
      vld_p1     <= 1'b0;
      credits_p1 <= CRED_MAX;
      err_p1     <= 1'b0;
      state_p1   <= IDLE;
    end else begin
      vld_p1     <= pop;
      credits_p1 <= next_credits(credits_p1, pop, link.credit_i);
      if (pop) begin
        flit_p1  <= link.buf_data_i;
        state_p1 <= next_state(state_p1, ftype);
      end
      if (credit_overflow(credits_p1, pop, link.credit_i) ||
          (pop && frame_error(state_p1, ftype))) begin
        err_p1 <= 1'b1;
      end
    end
  end

  assign link.flit_o       = flit_p1;
  assign link.flit_valid_o = vld_p1;
  assign link.credits_o    = credits_p1;
  assign link.pkt_active_o = (state_p1 == ACTIVE);
  assign link.err_o        = err_p1;

endmodule

// File: tb/tb_link_output_stage.sv
// Directed bench for link_output_stage: a small array-backed buffer feeds the stage,
// and each scenario task checks the link, credit and framing outputs cycle by cycle.
module tb_link_output_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         n_tests = 0;
  int         n_fail  = 0;

  logic [15:0] mem [32];
  logic [4:0]  rd = 5'd0;
  logic [4:0]  wr = 5'd0;

  link_output_stage_if #(.FLIT_SIZE(16), .CREDITS(8)) ifc ();

  link_output_stage #(.FLIT_SIZE(16), .CREDITS(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (ifc.slave)
  );

  always #5 clk = ~clk;

  assign ifc.buf_empty_i = (rd == wr);
  assign ifc.buf_data_i  = mem[rd];

  always @(posedge clk) begin
    if (rst && ifc.buf_read_o && (rd != wr)) rd <= rd + 5'd1;
  end

  task automatic push(input logic [15:0] f);
    mem[wr] = f;
    wr      = wr + 5'd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b0;
    ifc.hold_i    = 1'b0;
    ifc.credit_i  = 1'b0;
    wr            = rd;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    ifc.hold_i   = 1'b0;
    ifc.credit_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_tests++; if (ifc.flit_o !== 16'h0000) begin n_fail++; $display("FAIL reset_flit: got %h expected 0000", ifc.flit_o); end
    n_tests++; if (ifc.flit_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", ifc.flit_valid_o); end
    n_tests++; if (ifc.credits_o !== 4'd8) begin n_fail++; $display("FAIL reset_credits: got %0d expected 8", ifc.credits_o); end
    n_tests++; if (ifc.pkt_active_o !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", ifc.pkt_active_o); end
    n_tests++; if (ifc.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", ifc.err_o); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_packet();
    logic        e_rd   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        e_vld  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] e_flit [5] = '{16'h0000, 16'h0011, 16'h4022, 16'h8033, 16'h8033};
    logic [3:0]  e_cr   [5] = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd5};
    logic        e_act  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    ifc.hold_i = 1'b1;
    push(16'h0011);
    push(16'h4022);
    push(16'h8033);
    @(negedge clk);
    ifc.hold_i = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      n_tests++; if (ifc.buf_read_o !== e_rd[i]) begin n_fail++; $display("FAIL pkt_read[%0d]: got %b expected %b", i, ifc.buf_read_o, e_rd[i]); end
      n_tests++; if (ifc.flit_valid_o !== e_vld[i]) begin n_fail++; $display("FAIL pkt_valid[%0d]: got %b expected %b", i, ifc.flit_valid_o, e_vld[i]); end
      n_tests++; if (ifc.flit_o !== e_flit[i]) begin n_fail++; $display("FAIL pkt_flit[%0d]: got %h expected %h", i, ifc.flit_o, e_flit[i]); end
      n_tests++; if (ifc.credits_o !== e_cr[i]) begin n_fail++; $display("FAIL pkt_credits[%0d]: got %0d expected %0d", i, ifc.credits_o, e_cr[i]); end
      n_tests++; if (ifc.pkt_active_o !== e_act[i]) begin n_fail++; $display("FAIL pkt_active[%0d]: got %b expected %b", i, ifc.pkt_active_o, e_act[i]); end
    end
    n_tests++; if (ifc.err_o !== 1'b0) begin n_fail++; $display("FAIL pkt_err: got %b expected 0", ifc.err_o); end
  endtask

  task automatic test_credit_exhaust();
    int cnt;
    do_reset();
    ifc.hold_i = 1'b1;
    for (int i = 0; i < 10; i++) push(16'hC000 + 16'(i));
    @(negedge clk);
    ifc.hold_i = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk); #1;
      if (ifc.flit_valid_o === 1'b1) cnt++;
    end
    n_tests++; if (cnt != 8) begin n_fail++; $display("FAIL exhaust_count: got %0d expected 8", cnt); end
    n_tests++; if (ifc.credits_o !== 4'd0) begin n_fail++; $display("FAIL exhaust_credits: got %0d expected 0", ifc.credits_o); end
    n_tests++; if (ifc.buf_read_o !== 1'b0) begin n_fail++; $display("FAIL exhaust_read: got %b expected 0", ifc.buf_read_o); end
    n_tests++; if (ifc.flit_o !== 16'hC007) begin n_fail++; $display("FAIL exhaust_flit: got %h expected C007", ifc.flit_o); end
    @(negedge clk);
    ifc.credit_i = 1'b1;
    @(negedge clk);
    ifc.credit_i = 1'b0;
    #1;
    n_tests++; if (ifc.credits_o !== 4'd1) begin n_fail++; $display("FAIL refill_credits: got %0d expected 1", ifc.credits_o); end
    n_tests++; if (ifc.buf_read_o !== 1'b1) begin n_fail++; $display("FAIL refill_read: got %b expected 1", ifc.buf_read_o); end
    cnt = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (ifc.flit_valid_o === 1'b1) cnt++;
    end
    n_tests++; if (cnt != 1) begin n_fail++; $display("FAIL refill_count: got %0d expected 1", cnt); end
    n_tests++; if (ifc.credits_o !== 4'd0) begin n_fail++; $display("FAIL refill_credits_end: got %0d expected 0", ifc.credits_o); end
    n_tests++; if (ifc.flit_o !== 16'hC008) begin n_fail++; $display("FAIL refill_flit: got %h expected C008", ifc.flit_o); end
    n_tests++; if (ifc.err_o !== 1'b0) begin n_fail++; $display("FAIL exhaust_err: got %b expected 0", ifc.err_o); end
  endtask

  task automatic test_credit_same_cycle();
    do_reset();
    ifc.hold_i = 1'b1;
    for (int i = 0; i < 5; i++) push(16'hC010 + 16'(i));
    @(negedge clk);
    ifc.hold_i = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    n_tests++; if (ifc.credits_o !== 4'd3) begin n_fail++; $display("FAIL same_pre_credits: got %0d expected 3", ifc.credits_o); end
    push(16'hC0AA);
    ifc.credit_i = 1'b1;
    #1;
    n_tests++; if (ifc.buf_read_o !== 1'b1) begin n_fail++; $display("FAIL same_read: got %b expected 1", ifc.buf_read_o); end
    @(negedge clk);
    ifc.credit_i = 1'b0;
    #1;
    n_tests++; if (ifc.credits_o !== 4'd3) begin n_fail++; $display("FAIL same_credits: got %0d expected 3", ifc.credits_o); end
    n_tests++; if (ifc.flit_valid_o !== 1'b1) begin n_fail++; $display("FAIL same_valid: got %b expected 1", ifc.flit_valid_o); end
    n_tests++; if (ifc.flit_o !== 16'hC0AA) begin n_fail++; $display("FAIL same_flit: got %h expected C0AA", ifc.flit_o); end
  endtask

  task automatic test_credit_overflow();
    do_reset();
    @(negedge clk);
    ifc.credit_i = 1'b1;
    @(negedge clk);
    ifc.credit_i = 1'b0;
    #1;
    n_tests++; if (ifc.credits_o !== 4'd8) begin n_fail++; $display("FAIL ovf_credits: got %0d expected 8", ifc.credits_o); end
    n_tests++; if (ifc.err_o !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b expected 1", ifc.err_o); end
    repeat (3) @(negedge clk);
    #1;
    n_tests++; if (ifc.err_o !== 1'b1) begin n_fail++; $display("FAIL ovf_err_sticky: got %b expected 1", ifc.err_o); end
  endtask

  task automatic test_framing_errors();
    do_reset();
    push(16'h4055);
    @(negedge clk); #1;
    n_tests++; if (ifc.flit_valid_o !== 1'b1) begin n_fail++; $display("FAIL body_valid: got %b expected 1", ifc.flit_valid_o); end
    n_tests++; if (ifc.flit_o !== 16'h4055) begin n_fail++; $display("FAIL body_flit: got %h expected 4055", ifc.flit_o); end
    n_tests++; if (ifc.err_o !== 1'b1) begin n_fail++; $display("FAIL body_err: got %b expected 1", ifc.err_o); end
    n_tests++; if (ifc.pkt_active_o !== 1'b0) begin n_fail++; $display("FAIL body_active: got %b expected 0", ifc.pkt_active_o); end
    do_reset();
    push(16'h0066);
    push(16'h0077);
    @(negedge clk); #1;
    n_tests++; if (ifc.pkt_active_o !== 1'b1) begin n_fail++; $display("FAIL hh_active1: got %b expected 1", ifc.pkt_active_o); end
    n_tests++; if (ifc.err_o !== 1'b0) begin n_fail++; $display("FAIL hh_err1: got %b expected 0", ifc.err_o); end
    @(negedge clk); #1;
    n_tests++; if (ifc.pkt_active_o !== 1'b1) begin n_fail++; $display("FAIL hh_active2: got %b expected 1", ifc.pkt_active_o); end
    n_tests++; if (ifc.err_o !== 1'b1) begin n_fail++; $display("FAIL hh_err2: got %b expected 1", ifc.err_o); end
    n_tests++; if (ifc.flit_o !== 16'h0077) begin n_fail++; $display("FAIL hh_flit: got %h expected 0077", ifc.flit_o); end
  endtask

  task automatic test_hold_then_reset();
    int nv;
    do_reset();
    ifc.hold_i = 1'b1;
    push(16'h0088);
    push(16'h4099);
    @(negedge clk);
    ifc.hold_i = 1'b0;
    @(negedge clk);
    ifc.hold_i = 1'b1;
    #1;
    n_tests++; if (ifc.credits_o !== 4'd7) begin n_fail++; $display("FAIL hold_credits: got %0d expected 7", ifc.credits_o); end
    n_tests++; if (ifc.pkt_active_o !== 1'b1) begin n_fail++; $display("FAIL hold_active: got %b expected 1", ifc.pkt_active_o); end
    n_tests++; if (ifc.buf_read_o !== 1'b0) begin n_fail++; $display("FAIL hold_read: got %b expected 0", ifc.buf_read_o); end
    n_tests++; if (ifc.flit_o !== 16'h0088) begin n_fail++; $display("FAIL hold_flit: got %h expected 0088", ifc.flit_o); end
    nv = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (ifc.flit_valid_o !== 1'b0) nv++;
    end
    n_tests++; if (nv != 0) begin n_fail++; $display("FAIL hold_pops: got %0d expected 0", nv); end
    n_tests++; if (ifc.credits_o !== 4'd7) begin n_fail++; $display("FAIL hold_credits_end: got %0d expected 7", ifc.credits_o); end
    n_tests++; if (ifc.pkt_active_o !== 1'b1) begin n_fail++; $display("FAIL hold_active_end: got %b expected 1", ifc.pkt_active_o); end
    #2 rst = 1'b0;
    #1;
    n_tests++; if (ifc.credits_o !== 4'd8) begin n_fail++; $display("FAIL midrst_credits: got %0d expected 8", ifc.credits_o); end
    n_tests++; if (ifc.pkt_active_o !== 1'b0) begin n_fail++; $display("FAIL midrst_active: got %b expected 0", ifc.pkt_active_o); end
    n_tests++; if (ifc.flit_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", ifc.flit_valid_o); end
    n_tests++; if (ifc.err_o !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b expected 0", ifc.err_o); end
    n_tests++; if (ifc.flit_o !== 16'h0000) begin n_fail++; $display("FAIL midrst_flit: got %h expected 0000", ifc.flit_o); end
    @(negedge clk);
    ifc.hold_i = 1'b0;
    rst        = 1'b1;
  endtask

  initial begin
    ifc.hold_i   = 1'b0;
    ifc.credit_i = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    test_reset();
    test_packet();
    test_credit_exhaust();
    test_credit_same_cycle();
    test_credit_overflow();
    test_framing_errors();
    test_hold_then_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
